// File: rtl/mp_core_pipe.sv
// Two-stage ALU + register-file core with valid/ready instruction handshake.
// Define MP_FORWARD_EN to forward ALU results on hazards instead of interlocking.
module mp_core_pipe #(
  parameter int DATA_W    = 32,
  parameter int REG_COUNT = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       instr,
  output logic [DATA_W-1:0] result,
  output logic              out_valid,
  output logic [4:0]        out_rd,
  output logic              illegal
);

  localparam int ADDR_W = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;

  typedef enum logic [5:0] {
    OP_NOP = 6'h00, OP_LDI = 6'h01, OP_NOT = 6'h02, OP_MAX = 6'h03,
    OP_AND = 6'h04, OP_ADD = 6'h05, OP_MIN = 6'h06, OP_NEG = 6'h07,
    OP_SUB = 6'h08, OP_AVG = 6'h0A, OP_XOR = 6'h0C, OP_ABS = 6'h0D,
    OP_OR  = 6'h0F
  } op_e;

  logic [DATA_W-1:0] rf [REG_COUNT];

  // decode stage register
  logic              d_valid;
  op_e               d_op;
  logic              d_ill;
  logic [ADDR_W-1:0] d_rd;
  logic [DATA_W-1:0] d_a;
  logic [DATA_W-1:0] d_b;

  logic [ADDR_W-1:0] rs1, rs2, rd;
  logic [31:0]       imm32;
  op_e               dec_op;
  logic              dec_ill;
  logic              d_wr;
  logic              haz1, haz2;
  logic              accept;
  logic [DATA_W-1:0] op_a, op_b;
  logic [DATA_W-1:0] alu_y;
  logic [DATA_W:0]   sum_ext;
  logic              unused_bits;

  assign rs1   = instr[6 +: ADDR_W];
  assign rs2   = instr[11 +: ADDR_W];
  assign rd    = instr[16 +: ADDR_W];
  assign imm32 = {{21{instr[31]}}, instr[31:21]};

  assign d_wr   = d_valid && (d_op != OP_NOP);
  assign haz1   = d_wr && (rs1 == d_rd);
  assign haz2   = d_wr && (rs2 == d_rd);
  assign accept = in_valid && in_ready;

  // Illegal opcodes are folded into NOP here so the execute stage sees only legal ops.
  always_comb begin
    dec_op  = OP_NOP;
    dec_ill = 1'b0;
    case (instr[5:0])
      6'h00, 6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07,
      6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0F: dec_op = op_e'(instr[5:0]);
      default: dec_ill = 1'b1;
    endcase
  end

`ifdef MP_FORWARD_EN
  assign in_ready = 1'b1;
  always_comb begin
    op_a = haz1 ? alu_y : rf[rs1];
    op_b = haz2 ? alu_y : rf[rs2];
    if (dec_op == OP_LDI) op_b = imm32[DATA_W-1:0];
  end
`else
  // Stall for one cycle; the bubble lets the writeback land before the re-read.
  assign in_ready = !(in_valid && (haz1 || haz2));
  always_comb begin
    op_a = rf[rs1];
    op_b = rf[rs2];
    if (dec_op == OP_LDI) op_b = imm32[DATA_W-1:0];
  end
`endif

  assign sum_ext = {d_a[DATA_W-1], d_a} + {d_b[DATA_W-1], d_b};

  always_comb begin
    alu_y = '0;
    case (d_op)
      OP_LDI: alu_y = d_b;
      OP_NOT: alu_y = ~d_a;
      OP_MAX: alu_y = ($signed(d_a) > $signed(d_b)) ? d_a : d_b;
      OP_MIN: alu_y = ($signed(d_a) < $signed(d_b)) ? d_a : d_b;
      OP_AND: alu_y = d_a & d_b;
      OP_OR:  alu_y = d_a | d_b;
      OP_XOR: alu_y = d_a ^ d_b;
      OP_ADD: alu_y = d_a + d_b;
      OP_SUB: alu_y = d_a - d_b;
      OP_NEG: alu_y = '0 - d_a;
      OP_AVG: alu_y = sum_ext[DATA_W:1];
      OP_ABS: alu_y = d_a[DATA_W-1] ? ('0 - d_a) : d_a;
      default: alu_y = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d_valid   <= 1'b0;
      d_op      <= OP_NOP;
      d_ill     <= 1'b0;
      d_rd      <= '0;
      d_a       <= '0;
      d_b       <= '0;
      result    <= '0;
      out_valid <= 1'b0;
      out_rd    <= '0;
      illegal   <= 1'b0;
      for (int unsigned i = 0; i < REG_COUNT; i++) rf[i] <= '0;
    end else begin
      out_valid <= d_wr;
      illegal   <= d_valid && d_ill;
      if (d_wr) begin
        rf[d_rd] <= alu_y;
        result   <= alu_y;
        out_rd   <= 5'(d_rd);
      end
      d_valid <= accept;
      if (accept) begin
        d_op  <= dec_op;
        d_ill <= dec_ill;
        d_rd  <= rd;
        d_a   <= op_a;
        d_b   <= op_b;
      end
    end
  end

  assign unused_bits = ^{instr, imm32, sum_ext[0]};

endmodule

// File: tb/tb_mp_core_pipe.sv
// Directed scoreboard bench for mp_core_pipe: a 32-bit/32-reg instance and an 8-bit/4-reg instance.
module tb_mp_core_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        iv0, iv1;
  logic [31:0] in0, in1;
  logic        rdy0, rdy1;
  logic [31:0] res0;
  logic [7:0]  res1;
  logic        ov0, ov1;
  logic [4:0]  ord0, ord1;
  logic        ill0, ill1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [31:0] d;
    logic [4:0]  rd;
  } exp_t;
  exp_t q0[$];
  exp_t q1[$];

  always #5 clk = ~clk;

  mp_core_pipe #(.DATA_W(32), .REG_COUNT(32)) dut0 (
    .clk(clk), .rst(rst), .in_valid(iv0), .in_ready(rdy0), .instr(in0),
    .result(res0), .out_valid(ov0), .out_rd(ord0), .illegal(ill0)
  );

  mp_core_pipe #(.DATA_W(8), .REG_COUNT(4)) dut1 (
    .clk(clk), .rst(rst), .in_valid(iv1), .in_ready(rdy1), .instr(in1),
    .result(res1), .out_valid(ov1), .out_rd(ord1), .illegal(ill1)
  );

`ifdef MP_FORWARD_EN
  localparam int EXP_STALL = 0;
`else
  localparam int EXP_STALL = 1;
`endif

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [5:0] op, input int rd, input int rs1,
                                      input int rs2, input logic [10:0] imm);
    return {imm, 5'(rd), 5'(rs2), 5'(rs1), op};
  endfunction

  // scoreboard monitors
  always @(negedge clk) begin
    exp_t e;
    if (ov0 === 1'b1) begin
      chk("dut0_unexpected_out", 32'(q0.size() != 0), 32'd1);
      if (q0.size() != 0) begin
        e = q0.pop_front();
        chk("dut0_result", res0, e.d);
        chk("dut0_out_rd", 32'(ord0), 32'(e.rd));
      end
    end
    if (ov1 === 1'b1) begin
      chk("dut1_unexpected_out", 32'(q1.size() != 0), 32'd1);
      if (q1.size() != 0) begin
        e = q1.pop_front();
        chk("dut1_result", 32'(res1), e.d);
        chk("dut1_out_rd", 32'(ord1), 32'(e.rd));
      end
    end
  end

  // Called just after a posedge; returns just after the accepting posedge.
  task automatic send(input bit sel, input logic [31:0] ins, input bit wr,
                      input logic [31:0] exp, input logic [4:0] erd, output int stalls);
    exp_t e;
    stalls = 0;
    if (sel) begin iv1 = 1'b1; in1 = ins; end
    else     begin iv0 = 1'b1; in0 = ins; end
    forever begin
      @(negedge clk);
      if ((sel ? rdy1 : rdy0) === 1'b1) break;
      stalls++;
      if (stalls > 20) break;
    end
    if (stalls > 20) chk("accept_timeout", 32'(stalls), 32'd0);
    @(posedge clk);
    if (wr && stalls <= 20) begin
      e.d = exp;
      e.rd = erd;
      if (sel) q1.push_back(e);
      else     q0.push_back(e);
    end
    #1;
    iv0 = 1'b0;
    iv1 = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int s;
    rst = 1'b1;
    iv0 = 1'b0; iv1 = 1'b0;
    in0 = '0;   in1 = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    @(negedge clk);
    chk("rst_result", res0, 32'h0);
    chk("rst_out_valid", 32'(ov0), 32'h0);
    chk("rst_out_rd", 32'(ord0), 32'h0);
    chk("rst_illegal", 32'(ill0), 32'h0);
    chk("rst_in_ready", 32'(rdy0), 32'h1);
    @(posedge clk); #1;

    // 1: directed sequence with NOPs and latency check
    send(0, enc(6'h01, 1, 0, 0, 11'h208), 1, 32'h208, 5'd1, s);
    @(negedge clk);
    chk("lat_edge_k", 32'(ov0), 32'h0);
    @(negedge clk);
    chk("lat_edge_k1", 32'(ov0), 32'h1);
    @(negedge clk);
    chk("pulse_width", 32'(ov0), 32'h0);
    @(posedge clk); #1;
    send(0, enc(6'h00, 0, 0, 0, 11'h0), 0, 32'h0, 5'd0, s);
    send(0, enc(6'h01, 2, 0, 0, 11'h178), 1, 32'h178, 5'd2, s);
    send(0, enc(6'h00, 0, 0, 0, 11'h0), 0, 32'h0, 5'd0, s);
    send(0, enc(6'h05, 0, 1, 2, 11'h0), 1, 32'h380, 5'd0, s);
    idle(3);

    // 2: back-to-back dependency
    send(0, enc(6'h01, 5, 0, 0, 11'h005), 1, 32'h5, 5'd5, s);
    chk("ldi_no_stall", 32'(s), 32'd0);
    send(0, enc(6'h05, 6, 5, 5, 11'h0), 1, 32'hA, 5'd6, s);
    chk("hazard_stall_cycles", 32'(s), 32'(EXP_STALL));
    idle(3);

    // 3: signed ops with R7=-6, R8=3
    send(0, enc(6'h01, 7, 0, 0, 11'h7FA), 1, 32'hFFFFFFFA, 5'd7, s);
    send(0, enc(6'h01, 8, 0, 0, 11'h003), 1, 32'h3, 5'd8, s);
    send(0, enc(6'h0A, 9, 7, 8, 11'h0), 1, 32'hFFFFFFFE, 5'd9, s);
    send(0, enc(6'h03, 10, 7, 8, 11'h0), 1, 32'h3, 5'd10, s);
    send(0, enc(6'h06, 11, 7, 8, 11'h0), 1, 32'hFFFFFFFA, 5'd11, s);
    send(0, enc(6'h08, 12, 8, 7, 11'h0), 1, 32'h9, 5'd12, s);
    send(0, enc(6'h04, 13, 7, 8, 11'h0), 1, 32'h2, 5'd13, s);
    send(0, enc(6'h0C, 14, 7, 8, 11'h0), 1, 32'hFFFFFFF9, 5'd14, s);
    send(0, enc(6'h0F, 15, 7, 8, 11'h0), 1, 32'hFFFFFFFB, 5'd15, s);
    send(0, enc(6'h0D, 16, 7, 0, 11'h0), 1, 32'h6, 5'd16, s);
    send(0, enc(6'h07, 17, 8, 0, 11'h0), 1, 32'hFFFFFFFD, 5'd17, s);
    send(0, enc(6'h02, 18, 8, 0, 11'h0), 1, 32'hFFFFFFFC, 5'd18, s);
    idle(3);

    // 5: illegal opcode leaves result and R2 alone
    send(0, enc(6'h3F, 2, 1, 1, 11'h0), 0, 32'h0, 5'd0, s);
    @(negedge clk);
    @(negedge clk);
    chk("illegal_pulse", 32'(ill0), 32'h1);
    chk("illegal_no_out", 32'(ov0), 32'h0);
    chk("illegal_result_hold", res0, 32'hFFFFFFFC);
    @(negedge clk);
    chk("illegal_pulse_end", 32'(ill0), 32'h0);
    @(posedge clk); #1;
    send(0, enc(6'h0F, 19, 2, 2, 11'h0), 1, 32'h178, 5'd19, s);
    idle(3);

    // 4: narrow instance, wrap and aliasing
    send(1, enc(6'h01, 1, 0, 0, 11'h780), 1, 32'h80, 5'd1, s);
    send(1, enc(6'h0D, 2, 1, 0, 11'h0), 1, 32'h80, 5'd2, s);
    send(1, enc(6'h07, 3, 1, 0, 11'h0), 1, 32'h80, 5'd3, s);
    send(1, enc(6'h05, 0, 1, 1, 11'h0), 1, 32'h00, 5'd0, s);
    send(1, enc(6'h01, 5, 0, 0, 11'h007), 1, 32'h07, 5'd1, s);
    send(1, enc(6'h05, 3, 1, 0, 11'h0), 1, 32'h07, 5'd3, s);
    send(1, enc(6'h0A, 0, 1, 2, 11'h0), 1, 32'hC3, 5'd0, s);
    idle(3);

    // 6: reset while an ADD sits in D
    send(0, enc(6'h05, 20, 1, 2, 11'h0), 0, 32'h0, 5'd0, s);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 32'(ov0), 32'h0);
    chk("midrst_result", res0, 32'h0);
    chk("midrst_out_rd", 32'(ord0), 32'h0);
    @(negedge clk);
    chk("midrst_no_late_out", 32'(ov0), 32'h0);
    @(posedge clk); #1;
    for (int i = 0; i < 16; i++)
      send(0, enc(6'h05, i, 2 * i, 2 * i + 1, 11'h0), 1, 32'h0, 5'(i), s);

    // drain
    for (int i = 0; i < 20; i++) begin
      if (q0.size() == 0 && q1.size() == 0) break;
      @(posedge clk);
    end
    #1;
    chk("drain_q0", 32'(q0.size()), 32'd0);
    chk("drain_q1", 32'(q1.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
